// File: rtl/dma_copy.sv
// dma_copy: byte-at-a-time memory-to-memory DMA engine acting as a second initiator on the CPU bus.
// The CPU programs it through an 8-entry register window and it reports completion with done/irq.
module dma_copy #(
    parameter int ADDR_W = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [3:0]        cfg_addr,
    input  logic [7:0]        cfg_wr_data,
    input  logic              cfg_wr_en,
    output logic [7:0]        cfg_rd_data,
    output logic              bus_request,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd_req,
    input  logic [7:0]        bus_rd_data,
    input  logic              bus_ready,
    output logic [7:0]        bus_wr_data,
    output logic              bus_wr_en,
    output logic              irq
);
    typedef enum logic [2:0] {IDLE, REQ, RD_REQ, RD_WAIT, RD_DATA, WR, NEXT} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] src_q, dst_q, len_q, src_d, dst_d, len_d;
    logic              src_fixed_q, dst_fixed_q, irq_en_q, done_q, start_q, abort_q;
    logic [15:0]       src16, dst16, len16;
    logic              busy, cfg_ok, unused_bits;
    assign busy        = state_q != IDLE;
    assign cfg_ok      = cfg_wr_en && !busy;
    assign src16       = 16'(src_q);
    assign dst16       = 16'(dst_q);
    assign len16       = 16'(len_q);
    assign irq         = done_q && irq_en_q;
    assign unused_bits = ^cfg_wr_data[6:4];
    // Working registers advance on the WR->NEXT edge so a stalled NEXT never re-applies the step.
    assign src_d = state_q == WR ? src_q + ADDR_W'(!src_fixed_q)
                 : cfg_ok && cfg_addr == 4'd0 ? ADDR_W'({src16[15:8], cfg_wr_data})
                 : cfg_ok && cfg_addr == 4'd1 ? ADDR_W'({cfg_wr_data, src16[7:0]})
                 : src_q;
    assign dst_d = state_q == WR ? dst_q + ADDR_W'(!dst_fixed_q)
                 : cfg_ok && cfg_addr == 4'd2 ? ADDR_W'({dst16[15:8], cfg_wr_data})
                 : cfg_ok && cfg_addr == 4'd3 ? ADDR_W'({cfg_wr_data, dst16[7:0]})
                 : dst_q;
    assign len_d = state_q == WR ? len_q - ADDR_W'(1)
                 : cfg_ok && cfg_addr == 4'd4 ? ADDR_W'({len16[15:8], cfg_wr_data})
                 : cfg_ok && cfg_addr == 4'd5 ? ADDR_W'({cfg_wr_data, len16[7:0]})
                 : len_q;
    always_comb begin
        case (cfg_addr)
            4'd0:    cfg_rd_data = src16[7:0];
            4'd1:    cfg_rd_data = src16[15:8];
            4'd2:    cfg_rd_data = dst16[7:0];
            4'd3:    cfg_rd_data = dst16[15:8];
            4'd4:    cfg_rd_data = len16[7:0];
            4'd5:    cfg_rd_data = len16[15:8];
            4'd6:    cfg_rd_data = {4'b0, irq_en_q, dst_fixed_q, src_fixed_q, 1'b0};
            4'd7:    cfg_rd_data = {6'b0, done_q, busy};
            default: cfg_rd_data = 8'h00;
        endcase
    end
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            src_fixed_q <= 1'b0;
            dst_fixed_q <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            bus_request <= 1'b0;
            bus_rd_req  <= 1'b0;
            bus_wr_en   <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= 8'h00;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            bus_rd_req <= 1'b0;
            bus_wr_en  <= 1'b0;
            start_q    <= cfg_ok && cfg_addr == 4'd6 && cfg_wr_data[0];
            if (cfg_wr_en && cfg_addr == 4'd6) begin
                if (busy) abort_q <= abort_q | cfg_wr_data[7];
                else {irq_en_q, dst_fixed_q, src_fixed_q} <= cfg_wr_data[3:1];
            end
            if (cfg_wr_en && cfg_addr == 4'd7 && cfg_wr_data[1]) done_q <= 1'b0;
            // Later assignments below let a done-set override a same-cycle STATUS clear.
            case (state_q)
                IDLE: if (start_q) begin
                    done_q      <= len_q == '0;
                    state_q     <= len_q == '0 ? IDLE : REQ;
                    bus_request <= len_q != '0;
                end
                REQ: if (bus_grant) begin
                    state_q    <= RD_REQ;
                    bus_addr   <= src_q;
                    bus_rd_req <= 1'b1;
                end
                RD_REQ:  state_q <= RD_WAIT;
                RD_WAIT: if (!bus_ready) state_q <= RD_DATA;
                RD_DATA: if (bus_ready) begin
                    state_q     <= WR;
                    bus_wr_data <= bus_rd_data;
                    bus_addr    <= dst_q;
                    bus_wr_en   <= 1'b1;
                end
                WR: begin
                    state_q  <= NEXT;
                    bus_addr <= '0;
                end
                NEXT: if (len_q == '0 || abort_q) begin
                    state_q     <= IDLE;
                    bus_request <= 1'b0;
                    done_q      <= 1'b1;
                    abort_q     <= 1'b0;
                end else if (bus_grant) begin
                    state_q    <= RD_REQ;
                    bus_addr   <= src_q;
                    bus_rd_req <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: table-driven, hand-sequenced and randomized checks of dma_copy against a
// memory/log reference model with a bus responder.
module tb_dma_copy;
    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_wr_data, cfg_rd_data;
    logic        cfg_wr_en;
    logic        bus_request, bus_grant, bus_rd_req, bus_ready, bus_wr_en, irq;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rd_data, bus_wr_data;

    int          n_checks = 0, n_err = 0, req_seen = 0, rd_extra = 0;
    bit          rand_grant = 0;
    logic [7:0]  mem [65536];
    logic [15:0] reads [$];
    logic [23:0] writes [$];

    typedef struct {
        logic [15:0] src, dst, len;
        logic [7:0]  ctrl;
        int          cyc;
        logic [15:0] esrc, edst;
        logic [7:0]  ectrl;
        logic        eirq;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    dma_copy #(.ADDR_W(16)) dut (
        .sys_clk(clk), .reset(reset), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_wr_en(cfg_wr_en), .cfg_rd_data(cfg_rd_data), .bus_request(bus_request),
        .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_rd_req(bus_rd_req),
        .bus_rd_data(bus_rd_data), .bus_ready(bus_ready), .bus_wr_data(bus_wr_data),
        .bus_wr_en(bus_wr_en), .irq(irq)
    );

    // Read responder: ready drops through the cycle after the request, plus rd_extra cycles.
    initial begin
        bus_ready   = 1'b1;
        bus_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_rd_req) begin
                reads.push_back(bus_addr);
                bus_rd_data = mem[bus_addr];
                bus_ready   = 1'b0;
                repeat (2 + rd_extra) @(negedge clk);
                bus_ready = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_grant) bus_grant = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (bus_wr_en) writes.push_back({bus_addr, bus_wr_data});
        if (bus_request) req_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_addr = a; cfg_wr_data = d; cfg_wr_en = 1'b1;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic cfg_rd(input logic [3:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rd_data;
    endtask

    task automatic rd16(input logic [3:0] a, output logic [15:0] v);
        logic [7:0] lo, hi;
        cfg_rd(a, lo);
        cfg_rd(a + 4'd1, hi);
        v = {hi, lo};
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input logic [7:0] c);
        cfg_wr(4'd0, s[7:0]); cfg_wr(4'd1, s[15:8]);
        cfg_wr(4'd2, d[7:0]); cfg_wr(4'd3, d[15:8]);
        cfg_wr(4'd4, l[7:0]); cfg_wr(4'd5, l[15:8]);
        cfg_wr(4'd6, c);
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        bit ok = 0;
        cfg_addr = 4'd7;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_rd_data[0]) cyc++;
            else begin ok = 1; break; end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    // Expected bus traffic: byte i is read from s(+i) and written to d(+i), all mod 2^16.
    task automatic chk_traffic(input string nm, input logic [15:0] s, input logic [15:0] d,
                               input int n, input logic [7:0] c);
        logic [15:0] sa, da;
        chk({nm, "_nreads"}, reads.size(), n);
        chk({nm, "_nwrites"}, writes.size(), n);
        for (int i = 0; i < n && i < reads.size() && i < writes.size(); i++) begin
            sa = s + (c[1] ? 16'd0 : 16'(i));
            da = d + (c[2] ? 16'd0 : 16'(i));
            chk({nm, "_rd_addr"}, 32'(reads[i]), 32'(sa));
            chk({nm, "_wr"}, 32'(writes[i]), 32'({da, mem[sa]}));
        end
    endtask

    task automatic run_copy(input string nm, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [7:0] c, input int exp_cyc,
                            input logic [15:0] esrc, input logic [15:0] edst,
                            input logic [7:0] ectrl, input logic eirq);
        int cyc;
        logic [15:0] v;
        logic [7:0] b;
        cfg_wr(4'd7, 8'h02);
        reads.delete();
        writes.delete();
        prog(s, d, l, c);
        wait_idle(400, cyc);
        if (exp_cyc >= 0) chk({nm, "_busy_cycles"}, cyc, exp_cyc);
        chk_traffic(nm, s, d, int'(l), c);
        rd16(4'd0, v); chk({nm, "_src_end"}, 32'(v), 32'(esrc));
        rd16(4'd2, v); chk({nm, "_dst_end"}, 32'(v), 32'(edst));
        rd16(4'd4, v); chk({nm, "_len_end"}, 32'(v), 32'd0);
        cfg_rd(4'd6, b); chk({nm, "_ctrl_rb"}, 32'(b), 32'(ectrl));
        cfg_rd(4'd7, b); chk({nm, "_status"}, 32'(b), 32'h02);
        chk({nm, "_irq"}, 32'(irq), 32'(eirq));
        chk({nm, "_req_off"}, 32'(bus_request), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [15:0] v, s, d, l;
        logic [7:0] b, c;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22; mem[16'h1002] = 8'h33;
        tbl[0] = '{16'h1000, 16'h2000, 16'd3, 8'h09, 16, 16'h1003, 16'h2003, 8'h08, 1'b1};
        tbl[1] = '{16'hFFFF, 16'h3000, 16'd2, 8'h05, 11, 16'h0001, 16'h3000, 8'h04, 1'b0};
        tbl[2] = '{16'h4000, 16'hFFFE, 16'd4, 8'h03, 21, 16'h4000, 16'h0002, 8'h02, 1'b0};
        tbl[3] = '{16'h0010, 16'h0020, 16'd1, 8'h0F, 6, 16'h0010, 16'h0020, 8'h0E, 1'b1};
        cfg_addr = 4'd0; cfg_wr_data = 8'h00; cfg_wr_en = 1'b0; bus_grant = 1'b1;

        #12;
        chk("rst_request", 32'(bus_request), 0);
        chk("rst_rd_req", 32'(bus_rd_req), 0);
        chk("rst_wr_en", 32'(bus_wr_en), 0);
        chk("rst_addr", 32'(bus_addr), 0);
        chk("rst_wr_data", 32'(bus_wr_data), 0);
        chk("rst_irq", 32'(irq), 0);
        cfg_rd(4'd7, b); chk("rst_status", 32'(b), 0);
        rd16(4'd0, v); chk("rst_src", 32'(v), 0);
        @(negedge clk);
        reset = 1'b0;

        cfg_wr(4'd6, 8'h80);
        cfg_rd(4'd6, b); chk("abort_idle_ctrl", 32'(b), 0);
        cfg_rd(4'd7, b); chk("abort_idle_status", 32'(b), 0);

        for (int k = 0; k < 4; k++)
            run_copy($sformatf("tbl%0d", k), tbl[k].src, tbl[k].dst, tbl[k].len, tbl[k].ctrl,
                     tbl[k].cyc, tbl[k].esrc, tbl[k].edst, tbl[k].ectrl, tbl[k].eirq);

        // Zero length: done one cycle after the start edge, bus never requested.
        cfg_wr(4'd7, 8'h02);
        req_seen = 0;
        prog(16'h1234, 16'h5678, 16'd0, 8'h01);
        cfg_rd(4'd7, b); chk("zl_status_n0", 32'(b), 0);
        @(negedge clk);
        cfg_rd(4'd7, b); chk("zl_status_done", 32'(b), 32'h02);
        repeat (3) @(negedge clk);
        chk("zl_no_request", req_seen, 0);

        // Grant loss during byte 2 of 4, with a register write that must be ignored while busy.
        cfg_wr(4'd7, 8'h02);
        reads.delete(); writes.delete();
        prog(16'h5000, 16'h6000, 16'd4, 8'h01);
        repeat (7) @(negedge clk);
        bus_grant = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("gl_writes_mid", writes.size(), 2);
        cfg_wr(4'd0, 8'hAA);
        repeat (7) @(negedge clk);
        #1;
        chk("gl_req_held", 32'(bus_request), 1);
        chk("gl_writes_held", writes.size(), 2);
        chk("gl_reads_held", reads.size(), 2);
        chk("gl_no_strobe", 32'({bus_rd_req, bus_wr_en}), 0);
        bus_grant = 1'b1;
        wait_idle(100, cyc);
        chk_traffic("gl", 16'h5000, 16'h6000, 4, 8'h01);
        rd16(4'd0, v); chk("gl_src_end", 32'(v), 32'h5004);

        // Abort written during RD_WAIT of byte 2 of 5.
        cfg_wr(4'd7, 8'h02);
        reads.delete(); writes.delete();
        prog(16'h7000, 16'h8000, 16'd5, 8'h01);
        repeat (7) @(negedge clk);
        cfg_wr(4'd6, 8'h80);
        wait_idle(100, cyc);
        chk_traffic("ab", 16'h7000, 16'h8000, 2, 8'h01);
        rd16(4'd4, v); chk("ab_len_left", 32'(v), 3);
        cfg_rd(4'd7, b); chk("ab_status", 32'(b), 32'h02);

        // Asynchronous reset while the first write strobe is on the bus.
        cfg_wr(4'd7, 8'h02);
        prog(16'h1000, 16'h2000, 16'd3, 8'h01);
        repeat (5) @(negedge clk);
        chk("ar_pre_wr_en", 32'(bus_wr_en), 1);
        chk("ar_pre_addr", 32'(bus_addr), 32'h2000);
        #1 reset = 1'b1;
        #1;
        chk("ar_wr_en", 32'(bus_wr_en), 0);
        chk("ar_request", 32'(bus_request), 0);
        chk("ar_addr", 32'(bus_addr), 0);
        cfg_rd(4'd7, b); chk("ar_status", 32'(b), 0);
        @(negedge clk);
        reset = 1'b0;

        rand_grant = 1;
        for (int k = 0; k < 24; k++) begin
            s = 16'($urandom);
            d = 16'($urandom);
            l = 16'($urandom_range(1, 6));
            c = {4'b0, 3'($urandom), 1'b1};
            rd_extra = $urandom_range(0, 2);
            run_copy($sformatf("rnd%0d", k), s, d, l, c, -1,
                     s + (c[1] ? 16'd0 : l), d + (c[2] ? 16'd0 : l), {4'b0, c[3:1], 1'b0}, c[3]);
        end
        rand_grant = 0;
        bus_grant = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dma_copy.md
# dma_copy

Memory-to-memory DMA engine and second initiator on the system CPU bus. It uses the same read handshake as the 6502 core: a `bus_rd_req` rising edge, then `bus_ready` dipping low and returning high with data valid. Writes are single-cycle strobes. The CPU programs source, destination and length through a small register window, and the system decoder places that window at 0x94XX. The engine requests the bus, copies bytes one at a time, then releases the bus and raises a done flag and an optional IRQ.

## Interface
Parameters:
- `ADDR_W`, default 16: bus address width. All address and length arithmetic is modulo 2^ADDR_W.

Ports:
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_addr`  in  4  register offset (the system drives `cpu_addr[3:0]`).
- `cfg_wr_data`  in  8  register write data.
- `cfg_wr_en`  in  1  register write strobe, already qualified by the decoder's chip select.
- `cfg_rd_data`  out  8  combinational readback of the register at `cfg_addr`.
- `bus_request`  out  1  engine wants the bus.
- `bus_grant`  in  1  system has parked the CPU and muxed the engine onto the bus.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_rd_req`  out  1  read request; the responder detects its rising edge.
- `bus_rd_data`  in  8  read data, valid when `bus_ready` returns high.
- `bus_ready`  in  1  responder ready; low while a read is pending.
- `bus_wr_data`  out  8  write data.
- `bus_wr_en`  out  1  one-cycle write strobe.
- `irq`  out  1  level interrupt, equal to `done & irq_en`.

## Operation
Registers:
- 0 `SRC_LO` and 1 `SRC_HI`: source address.
- 2 `DST_LO` and 3 `DST_HI`: destination address.
- 4 `LEN_LO` and 5 `LEN_HI`: byte count.
- 6 `CTRL` (write):
  - bit0 start (self-clearing);
  - bit1 `src_fixed`;
  - bit2 `dst_fixed`;
  - bit3 `irq_en`;
  - bit7 abort (self-clearing).
- 6 `CTRL` (read): bits 3:1 as stored; bits 0 and 7 read 0.
- 7 `STATUS` (read): bit0 busy, bit1 done.
- 7 `STATUS` (write): writing 1 to bit1 clears done.
- Registers 0-5 read back their live working values, so they advance during a transfer.

Write rules:
- Writes to 0-5 are ignored while busy.
- While busy, a write to `CTRL` acts only on abort. `src_fixed`, `dst_fixed`, `irq_en` and start are ignored.

Start behaviour:
- Start with LEN = 0: no bus activity, `done` set on the next cycle.
- Start with LEN ≠ 0: clear `done`, set busy, enter REQ.

State machine:
- IDLE.
- REQ: `bus_request`=1. Wait for `bus_grant`=1, then go to RD_REQ.
- RD_REQ: `bus_addr`=SRC, `bus_rd_req`=1 for exactly this cycle. Go to RD_WAIT.
- RD_WAIT: wait until `bus_ready`=0, then go to RD_DATA.
- RD_DATA: wait until `bus_ready`=1. Latch `bus_rd_data` into the data register and go to WR.
- WR: `bus_addr`=DST, `bus_wr_data`=latched byte, `bus_wr_en`=1 for one cycle. Go to NEXT.
- NEXT:
  - SRC += 1 unless `src_fixed`; DST += 1 unless `dst_fixed`; LEN -= 1. All wrap at 2^ADDR_W.
  - If LEN becomes 0, or abort is pending: go to IDLE, drop `bus_request`, set `done`, clear busy.
  - Else if `bus_grant`=1: go to RD_REQ.
  - Else hold in NEXT with `bus_request`=1 until grant returns.

Abort:
- Latched when written and honoured only in NEXT, so the in-flight byte always completes its write.
- The pending abort is cleared on entry to IDLE.
- Abort while IDLE has no effect.

Bus outputs outside the active states:
- `bus_rd_req` and `bus_wr_en` are 0 in every state other than RD_REQ and WR respectively.
- `bus_addr` is 0 in IDLE and REQ.

## Timing
- Reset values:
  - All registers 0; state IDLE.
  - `bus_request`=0, `bus_rd_req`=0, `bus_wr_en`=0, `bus_addr`=0, `bus_wr_data`=0, `irq`=0.
  - Reset mid-transfer drops every bus output immediately (asynchronous).
- Register writes take effect on the edge that samples `cfg_wr_en`. Start is acted on at the next edge.
- Per-byte cost, with a responder that drops `bus_ready` for one cycle starting the cycle after the `bus_rd_req` edge, is 5 cycles:
  - RD_REQ, RD_WAIT, RD_DATA, WR, NEXT.
  - `bus_rd_req` is low for at least 4 cycles between requests, so every request produces a clean rising edge.
- Grant latency is unbounded. The engine only waits; it never times out.
- `done` and `irq` rise on the edge that leaves NEXT for IDLE.
- If a `STATUS` clear and done-set occur in the same cycle, set wins.

## Test plan
- **Basic copy:** SRC=0x1000, DST=0x2000, LEN=3, source bytes 11 22 33, grant held high. Required: three reads at 0x1000–0x1002 and three writes of 11 22 33 to 0x2000–0x2002. Busy for 1 + 15 cycles; then `done`=1; `irq`=1 only when `irq_en` is set.
- **Zero length:** LEN=0 plus start. Required: `bus_request` never asserts; `done`=1 one cycle later.
- **Wrap and fixed modes:** SRC=0xFFFF, LEN=2, `dst_fixed`. Required: reads at 0xFFFF then 0x0000; both writes to the same DST; LEN reads back 0.
- **Grant loss:** drop `bus_grant` during byte 2 of 4. Required: the engine holds in NEXT with `bus_request`=1 and issues no strobes; it resumes on regrant and all 4 bytes are correct.
- **Abort:** abort written while in RD_WAIT of byte 2. Required: byte 2 is written, byte 3 is never read; `done`=1; remaining LEN reads N−2.
- **Async reset mid-transfer:** reset asserted during WR. Required: `bus_wr_en`, `bus_request` and `bus_addr` go to 0 without waiting for a clock edge; STATUS reads 0.
